// File: rtl/drsstc_pkg.sv
// drsstc_pkg
//   Shared types and constants for the DRSSTC drive path.
//   intr_state_t       : interrupter window state (IDLE, ARM, ON, DRAIN)
//   ONTIME_MAX_DEFAULT : default hard clamp on the on-window length in clk
//                        ticks (100 us at 50 MHz)
package drsstc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } intr_state_t;

  localparam int ONTIME_MAX_DEFAULT = 5000;

endpackage

// File: rtl/burst_interrupter_tick_counter.sv
// tick_counter
//   Modulo counter with a wrap strobe. It counts 0..limit-1 on every cycle
//   where step_i is high, and the limit is latched at the start of a run and
//   again at every wrap, so a limit change only takes effect for the next
//   full count cycle. Used as the interrupter period counter (step every clk)
//   and as the burst counter (step on each period tick).
// Ports
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clear_i  : synchronous clear of the count and of the latched limit
//   run_i    : counting allowed; low holds the count at 0
//   step_i   : advance the count by one this cycle
//   limit_i  : modulus; must be non-zero whenever run_i is high
//   count_o  : current count value
//   wrap_o   : high on the step where the count goes limit-1 -> 0
module tick_counter #(
  parameter int W = 20
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         run_i,
  input  logic         step_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] lim_q, lim_d;
  logic         live_q, live_d;
  logic [W-1:0] lim_eff;
  logic         last;

  // On the first cycle of a run there is no latched limit yet, so the live
  // input is used directly; afterwards the latched copy governs the wrap.
  always_comb begin
    lim_eff = live_q ? lim_q : limit_i;
    last    = (cnt_q == lim_eff - W'(1));
    wrap_o  = run_i & step_i & last & ~clear_i;
    count_o = cnt_q;
  end

  // Next-state: hold at zero when stopped, otherwise count and relatch the
  // limit at every wrap.
  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    live_d = live_q;
    if (clear_i || !run_i) begin
      cnt_d  = '0;
      lim_d  = limit_i;
      live_d = 1'b0;
    end else begin
      live_d = 1'b1;
      lim_d  = lim_eff;
      if (step_i) begin
        if (last) begin
          cnt_d = '0;
          lim_d = limit_i;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lim_q  <= '0;
      live_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      live_q <= live_d;
    end
  end

endmodule

// File: rtl/burst_interrupter.sv
// burst_interrupter
//   Interrupter for the DRSSTC path. Gates the oscillator from the selector
//   into on-windows that repeat every `period` clk ticks. A window arms on a
//   period tick, opens on the next oscillator rise, runs for
//   min(ontime, ONTIME_MAX) ticks and then drains until the oscillator falls
//   so the drive always ends on a complete half-cycle. Overcurrent aborts the
//   window and sets a sticky fault.
//   Optional feature macro: BURST_MODE_EN (adds burst_on_i / burst_off_i; the
//   block then fires burst_on ticks and skips burst_off ticks repeatedly).
// Ports
//   clk_i         : system clock
//   rst_i         : synchronous active-high reset
//   en_i          : interrupter enable; low for a cycle also clears fault
//   period_i      : period in ticks, 0 = disabled
//   ontime_i      : requested on-window in ticks, 0 = no pulse
//   gen_i         : oscillator from the selector
//   ocd_i         : overcurrent detect, active-high
//   burst_on_i    : (BURST_MODE_EN) ticks fired per burst, 0 = continuous
//   burst_off_i   : (BURST_MODE_EN) ticks skipped per burst, 0 = no gap
//   out_o         : gated drive, registered
//   active_o      : high while a window is open (ON or DRAIN)
//   fault_o       : sticky overcurrent flag
module burst_interrupter
  import drsstc_pkg::*;
#(
  parameter int PERIOD_W   = 20,
  parameter int ONTIME_W   = 16,
  parameter int ONTIME_MAX = ONTIME_MAX_DEFAULT
`ifdef BURST_MODE_EN
  ,
  parameter int BURST_W    = 8
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [ONTIME_W-1:0] ontime_i,
  input  logic                gen_i,
  input  logic                ocd_i,
`ifdef BURST_MODE_EN
  input  logic [BURST_W-1:0]  burst_on_i,
  input  logic [BURST_W-1:0]  burst_off_i,
`endif
  output logic                out_o,
  output logic                active_o,
  output logic                fault_o
);

  localparam logic [ONTIME_W-1:0] ONTIME_MAX_C = ONTIME_W'(ONTIME_MAX);
  localparam logic [ONTIME_W-1:0] DRAIN_LAST_C = ONTIME_W'(ONTIME_MAX - 1);

  intr_state_t         state_q, state_d;
  logic                gen_q;
  logic                out_q, out_d;
  logic                fault_q, fault_d;
  logic [ONTIME_W-1:0] on_cnt_q, on_cnt_d;
  logic [ONTIME_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [ONTIME_W-1:0] eff_on_q, eff_on_d;
  logic                rise, fall;
  logic                period_run;
  logic                tick;
  logic                burst_ok;
  logic [PERIOD_W-1:0] period_cnt_unused;

  assign rise = gen_i & ~gen_q;
  assign fall = ~gen_i & gen_q;

  // The period counter stops (and restarts from zero) whenever the block is
  // disabled, the period is zero or a fault is latched; an overcurrent clears
  // it in the same cycle it is seen.
  assign period_run = en_i && (period_i != '0) && !fault_q;

  tick_counter #(
    .W(PERIOD_W)
  ) u_period (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ocd_i),
    .run_i   (period_run),
    .step_i  (1'b1),
    .limit_i (period_i),
    .count_o (period_cnt_unused),
    .wrap_o  (tick)
  );

`ifdef BURST_MODE_EN
  // Burst counter steps once per period tick over burst_on+burst_off slots;
  // a tick may arm only while the slot index is inside the burst_on part.
  logic [BURST_W:0] burst_len;
  logic [BURST_W:0] burst_idx;
  logic             burst_run;
  logic             burst_clear;
  logic             burst_wrap_unused;

  assign burst_len   = {1'b0, burst_on_i} + {1'b0, burst_off_i};
  assign burst_run   = (burst_on_i != '0);
  assign burst_clear = ocd_i | fault_q | ~en_i;

  tick_counter #(
    .W(BURST_W + 1)
  ) u_burst (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (burst_clear),
    .run_i   (burst_run),
    .step_i  (tick),
    .limit_i (burst_len),
    .count_o (burst_idx),
    .wrap_o  (burst_wrap_unused)
  );

  assign burst_ok = !burst_run || (burst_idx < {1'b0, burst_on_i});
`else
  assign burst_ok = 1'b1;
`endif

  // Window FSM. Overcurrent and disable override everything and drop the
  // window immediately without draining. Ticks seen while a window is open
  // are ignored, so long on-times simply skip periods.
  always_comb begin
    state_d     = state_q;
    on_cnt_d    = on_cnt_q;
    drain_cnt_d = drain_cnt_q;
    eff_on_d    = eff_on_q;
    if (ocd_i || !en_i) begin
      state_d     = IDLE;
      on_cnt_d    = '0;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick && (ontime_i != '0) && burst_ok) begin
            state_d = ARM;
          end
        end
        ARM: begin
          if (rise) begin
            if (ontime_i == '0) begin
              state_d = IDLE;
            end else begin
              state_d  = ON;
              on_cnt_d = '0;
              eff_on_d = (ontime_i > ONTIME_MAX_C) ? ONTIME_MAX_C : ontime_i;
            end
          end else if (tick) begin
            state_d = IDLE;
          end
        end
        ON: begin
          if (on_cnt_q == eff_on_q - ONTIME_W'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            on_cnt_d = on_cnt_q + ONTIME_W'(1);
          end
        end
        DRAIN: begin
          if (fall || (drain_cnt_q == DRAIN_LAST_C)) begin
            state_d = IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q + ONTIME_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The drive uses the next state so the first oscillator high after the
  // arming rise is passed through with exactly one clk of latency.
  always_comb begin
    out_d   = gen_i & ((state_d == ON) || (state_d == DRAIN));
    fault_d = fault_q;
    if (ocd_i) begin
      fault_d = 1'b1;
    end else if (!en_i) begin
      fault_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gen_q       <= 1'b0;
      out_q       <= 1'b0;
      fault_q     <= 1'b0;
      on_cnt_q    <= '0;
      drain_cnt_q <= '0;
      eff_on_q    <= '0;
    end else begin
      state_q     <= state_d;
      gen_q       <= gen_i;
      out_q       <= out_d;
      fault_q     <= fault_d;
      on_cnt_q    <= on_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      eff_on_q    <= eff_on_d;
    end
  end

  assign out_o    = out_q;
  assign active_o = (state_q == ON) || (state_q == DRAIN);
  assign fault_o  = fault_q;

endmodule

// File: tb/tb_burst_interrupter.sv
// tb_burst_interrupter
//   Randomised and directed stimulus for burst_interrupter. A behavioural
//   model written from the window rules predicts out/active/fault for every
//   cycle; predictions go into a scoreboard queue and a monitor on the
//   falling edge pops and compares them against the registered outputs.
module tb_burst_interrupter;

  localparam int OnMax = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] period;
  logic [15:0] ontime;
  logic        gen;
  logic        ocd;
  logic [7:0]  burstOn;
  logic [7:0]  burstOff;
  logic        out_o;
  logic        active_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string phase = "reset";

  typedef struct {
    int    cyc;
    bit    out;
    bit    act;
    bit    flt;
    string tag;
  } expEntry_t;

  expEntry_t sb[$];

  burst_interrupter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .period_i   (period),
    .ontime_i   (ontime),
    .gen_i      (gen),
    .ocd_i      (ocd),
`ifdef BURST_MODE_EN
    .burst_on_i (burstOn),
    .burst_off_i(burstOff),
`endif
    .out_o      (out_o),
    .active_o   (active_o),
    .fault_o    (fault_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator generator: genHalf > 0 toggles every genHalf cycles,
  // 0 holds low, negative holds high.
  int genHalf = 10;
  int genCnt = 0;

  // Reference model state: position inside the current period, whether the
  // next tick will arm, remaining on-window ticks, age inside the drain.
  int mPos = 0;
  int mPer = 0;
  bit mRun = 0;
  int mIdx = 0;
  bit mArmed = 0;
  int mOnLeft = 0;
  int mDrainAge = -1;
  bit mFault = 0;
  bit mGenPrev = 0;
  bit expOut = 0;
  bit expAct = 0;
  int bOn = 0;
  int bOff = 0;

  task automatic dropWindow();
    mArmed = 0;
    mOnLeft = 0;
    mDrainAge = -1;
  endtask

  task automatic modelStep();
    bit rise, fall, tick, allowed, faultOld, runPer;
    if (rst) begin
      mPos = 0; mPer = 0; mRun = 0; mIdx = 0; mFault = 0; mGenPrev = 0;
      dropWindow();
      expOut = 0; expAct = 0;
      return;
    end
    rise = gen && !mGenPrev;
    fall = !gen && mGenPrev;
    faultOld = mFault;
    tick = 0;
    runPer = en && (period != 0) && !faultOld;
    if (ocd || !runPer) begin
      mPos = 0; mRun = 0;
    end else begin
      if (!mRun) begin mPer = int'(period); mRun = 1; end
      if (mPos == mPer - 1) begin
        tick = 1; mPos = 0; mPer = int'(period);
      end else mPos++;
    end
    allowed = (bOn == 0) || (mIdx < bOn);
    if (ocd || faultOld || !en || bOn == 0) mIdx = 0;
    else if (tick) mIdx = (mIdx + 1) % (bOn + bOff);
    if (ocd) begin
      mFault = 1; dropWindow();
    end else if (!en) begin
      mFault = 0; dropWindow();
    end else if (mArmed) begin
      if (rise) begin
        mArmed = 0;
        if (ontime != 0) mOnLeft = (int'(ontime) > OnMax) ? OnMax : int'(ontime);
      end else if (tick) mArmed = 0;
    end else if (mOnLeft > 0) begin
      mOnLeft--;
      if (mOnLeft == 0) mDrainAge = 0;
    end else if (mDrainAge >= 0) begin
      if (fall || mDrainAge == OnMax - 1) mDrainAge = -1;
      else mDrainAge++;
    end else if (tick && ontime != 0 && allowed) begin
      mArmed = 1;
    end
    expAct = (mOnLeft > 0) || (mDrainAge >= 0);
    expOut = gen && expAct;
    mGenPrev = gen;
  endtask

  // Advance one clock: update the oscillator, predict, enqueue, then let the
  // edge happen and move inputs 1 time unit after it.
  task automatic tickOnce();
    expEntry_t e;
    if (genHalf == 0) gen = 1'b0;
    else if (genHalf < 0) gen = 1'b1;
    else begin
      genCnt++;
      if (genCnt >= genHalf) begin gen = ~gen; genCnt = 0; end
    end
    modelStep();
    e.cyc = cyc + 1; e.out = expOut; e.act = expAct; e.flt = mFault; e.tag = phase;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) tickOnce();
  endtask

  task automatic setBurst(input int on, input int off);
    burstOn = 8'(on); burstOff = 8'(off); bOn = on; bOff = off;
  endtask

  // Run until the model is well inside an ON window (bounded).
  task automatic runIntoOn();
    for (int i = 0; i < 20000 && !(mOnLeft > 0 && mOnLeft < 60); i++) tickOnce();
  endtask

  task automatic checkOutput(input expEntry_t e);
    checks++;
    if (out_o !== e.out) begin
      errors++;
      $display("[TB] FAIL %s out cyc=%0d got=%b expected=%b", e.tag, e.cyc, out_o, e.out);
    end
    checks++;
    if (active_o !== e.act) begin
      errors++;
      $display("[TB] FAIL %s active cyc=%0d got=%b expected=%b", e.tag, e.cyc, active_o, e.act);
    end
    checks++;
    if (fault_o !== e.flt) begin
      errors++;
      $display("[TB] FAIL %s fault cyc=%0d got=%b expected=%b", e.tag, e.cyc, fault_o, e.flt);
    end
  endtask

  // Monitor: compare every prediction whose clock edge has already happened.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; period = 20'd1000; ontime = 16'd100;
    gen = 1'b0; ocd = 1'b0;
    setBurst(0, 0);

    phase = "reset";
    genHalf = 1;
    applyStimulus(3);
    rst = 1'b0;

    phase = "basic";
    genHalf = 10;
    applyStimulus(3200);

    phase = "clamp";
    period = 20'd8000; ontime = 16'd60000;
    applyStimulus(12000);

    phase = "ocd";
    period = 20'd1000; ontime = 16'd100;
    runIntoOn();
    ocd = 1'b1; tickOnce(); ocd = 1'b0;
    applyStimulus(60);
    en = 1'b0; tickOnce(); en = 1'b1;
    applyStimulus(2500);

    phase = "drain_timeout";
    period = 20'd8000;
    runIntoOn();
    genHalf = -1;
    applyStimulus(5200);
    genHalf = 10;
    applyStimulus(300);

    phase = "no_gen";
    period = 20'd500; genHalf = 0;
    applyStimulus(1500);

    phase = "random";
    for (int seg = 0; seg < 40; seg++) begin
      period = ($urandom_range(0, 15) == 0) ? 20'd0 : 20'($urandom_range(20, 400));
      case ($urandom_range(0, 4))
        0: ontime = 16'd0;
        1: ontime = 16'($urandom_range(1, 5));
        2, 3: ontime = 16'($urandom_range(1, 400));
        default: ontime = 16'($urandom_range(400, 800));
      endcase
      genHalf = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 15));
      for (int i = 0; i < 300; i++) begin
        rst = ($urandom_range(0, 2999) == 0);
        en  = ($urandom_range(0, 399) != 0);
        ocd = ($urandom_range(0, 499) == 0);
        tickOnce();
      end
      rst = 1'b0; en = 1'b1; ocd = 1'b0;
    end

`ifdef BURST_MODE_EN
    phase = "burst";
    en = 1'b0; tickOnce();
    setBurst(3, 2);
    period = 20'd200; ontime = 16'd50; genHalf = 5; en = 1'b1;
    applyStimulus(2400);

    phase = "burst_random";
    for (int seg = 0; seg < 10; seg++) begin
      en = 1'b0; tickOnce();
      setBurst(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      period = 20'($urandom_range(30, 120));
      ontime = 16'($urandom_range(1, 40));
      genHalf = int'($urandom_range(2, 8));
      en = 1'b1;
      for (int i = 0; i < 500; i++) begin
        ocd = ($urandom_range(0, 699) == 0);
        tickOnce();
      end
      ocd = 1'b0;
    end
`endif

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
